// File: rtl/sram_512x28_ctrl.sv
// Front-end controller for a 512x28 bit-write-enable SRAM macro: post-reset zero-fill,
// round-robin sharing between two requesters, fixed one-cycle read return.
module sram_512x28_ctrl #(
    parameter bit         InitOnReset = 1'b1,
    parameter logic [2:0] MemMc       = 3'b000,
    parameter logic       MemMcen     = 1'b0,
    parameter logic [1:0] MemWa       = 2'b00,
    parameter logic [1:0] MemWpulse   = 2'b00,
    parameter logic       MemWpulseen = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        we0_i,
    input  logic [8:0]  addr0_i,
    input  logic [27:0] wdata0_i,
    input  logic [27:0] wmask0_i,
    input  logic        req1_i,
    input  logic        we1_i,
    input  logic [8:0]  addr1_i,
    input  logic [27:0] wdata1_i,
    input  logic [27:0] wmask1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        rvalid0_o,
    output logic        rvalid1_o,
    output logic [27:0] rdata0_o,
    output logic [27:0] rdata1_o,
    output logic        init_done_o,
    output logic        mem_ren_o,
    output logic        mem_wen_o,
    output logic [8:0]  mem_adr_o,
    output logic [27:0] mem_din_o,
    output logic [27:0] mem_wbeb_o,
    input  logic [27:0] mem_q_i,
    output logic [2:0]  mem_mc_o,
    output logic        mem_mcen_o,
    output logic        mem_clkbyp_o,
    output logic [1:0]  mem_wa_o,
    output logic [1:0]  mem_wpulse_o,
    output logic        mem_wpulseen_o,
    output logic        mem_fwen_o
);

    typedef enum logic {StInit, StRun} state_e;

    state_e      state_q, state_d;
    logic [8:0]  init_cnt_q, init_cnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic [1:0]  rd_pend_q, rd_pend_d;

    logic        sel_we;
    logic [8:0]  sel_addr;
    logic [27:0] sel_wdata;
    logic [27:0] sel_wmask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= InitOnReset ? StInit : StRun;
            init_cnt_q <= '0;
            last_gnt_q <= 1'b1;
            rd_pend_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        last_gnt_d = last_gnt_q;
        rd_pend_d  = '0;
        gnt0_o     = 1'b0;
        gnt1_o     = 1'b0;
        mem_ren_o  = 1'b0;
        mem_wen_o  = 1'b0;
        mem_adr_o  = '0;
        mem_din_o  = '0;
        mem_wbeb_o = '1;
        sel_we     = gnt1_o ? we1_i : we0_i;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_wmask  = '0;

        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 9'd1;
                if (init_cnt_q == 9'd511) begin
                    state_d = StRun;
                end
                // Pins held idle while reset is asserted, even though the state already reads INIT.
                if (!rst_i) begin
                    mem_wen_o  = 1'b1;
                    mem_adr_o  = init_cnt_q;
                    mem_wbeb_o = '0;
                end
            end
            StRun: begin
                if (!rst_i) begin
                    // On conflict the requester that did not win last time goes first.
                    gnt0_o = req0_i && (!req1_i || last_gnt_q);
                    gnt1_o = req1_i && !gnt0_o;
                end
                sel_we    = gnt1_o ? we1_i    : we0_i;
                sel_addr  = gnt1_o ? addr1_i  : addr0_i;
                sel_wdata = gnt1_o ? wdata1_i : wdata0_i;
                sel_wmask = gnt1_o ? wmask1_i : wmask0_i;
                if (gnt0_o || gnt1_o) begin
                    last_gnt_d = gnt1_o;
                    mem_ren_o  = !sel_we;
                    mem_wen_o  = sel_we;
                    mem_adr_o  = sel_addr;
                    mem_din_o  = sel_wdata;
                    mem_wbeb_o = ~sel_wmask;
                    rd_pend_d  = {gnt1_o && !sel_we, gnt0_o && !sel_we};
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign rvalid0_o   = rd_pend_q[0];
    assign rvalid1_o   = rd_pend_q[1];
    assign rdata0_o    = rd_pend_q[0] ? mem_q_i : '0;
    assign rdata1_o    = rd_pend_q[1] ? mem_q_i : '0;
    assign init_done_o = (state_q == StRun);

    assign mem_mc_o       = MemMc;
    assign mem_mcen_o     = MemMcen;
    assign mem_clkbyp_o   = 1'b0;
    assign mem_wa_o       = MemWa;
    assign mem_wpulse_o   = MemWpulse;
    assign mem_wpulseen_o = MemWpulseen;
    assign mem_fwen_o     = 1'b0;

endmodule
